// File: rtl/motor_pkg.sv
// Shared types and helpers for the dual H-bridge PWM motor drive.
// Holds the per-side state/direction encodings and the command decoder.
package motor_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_STOP = 2'd0,
        DIR_FWD  = 2'd1,
        DIR_REV  = 2'd2
    } dir_t;

    localparam int SIDES     = 2;
    localparam int SYNC_BITS = 3 * SIDES;

    // en low or equal direction lines (including the illegal 1/1 pair) mean stop
    function automatic dir_t decode_cmd(input logic en, input logic x1, input logic x2);
        if (!en || (x1 == x2)) begin
            return DIR_STOP;
        end else if (x2) begin
            return DIR_FWD;
        end else begin
            return DIR_REV;
        end
    endfunction

    // Width of a counter that must hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/motor_channel.sv
// One wheel side: STOP/RUN/DEAD sequencing, soft-start duty ramp, coast timer
// and the registered bridge outputs (direction pair plus PWM enable).
module motor_channel
    import motor_pkg::*;
#(
    parameter int DUTY      = 600,
    parameter int RAMP_STEP = 10,
    parameter int DEAD_CYC  = 50000,
    parameter int CNT_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  dir_t             cmd,
    input  logic [CNT_W-1:0] pwm_cnt,
    input  logic             wrap,
    output logic             in1,
    output logic             in2,
    output logic             pwm,
    output state_t           state
);

    localparam int DUTY_W = cnt_width(DUTY + 1);
    localparam int DEAD_W = cnt_width(DEAD_CYC);

    state_t              state_reg;
    dir_t                dir_reg;
    logic [DUTY_W-1:0]   duty_cur_reg;
    logic [DEAD_W-1:0]   dead_cnt_reg;
    logic                in1_reg;
    logic                in2_reg;
    logic                pwm_reg;

    logic [31:0]         ramp_sum;
    logic [DUTY_W-1:0]   duty_ramp;
    logic                dead_done;
    logic                pwm_level;

    // Saturating ramp evaluated in 32 bits so the sum can never wrap
    always_comb begin
        ramp_sum  = 32'(duty_cur_reg) + 32'(RAMP_STEP);
        duty_ramp = (ramp_sum >= 32'(DUTY)) ? DUTY_W'(DUTY) : DUTY_W'(ramp_sum);
        dead_done = (dead_cnt_reg == DEAD_W'(DEAD_CYC - 1));
        pwm_level = (32'(pwm_cnt) < 32'(duty_cur_reg));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_STOP;
            dir_reg      <= DIR_STOP;
            duty_cur_reg <= '0;
            dead_cnt_reg <= '0;
            in1_reg      <= 1'b0;
            in2_reg      <= 1'b0;
            pwm_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_STOP: begin
                    duty_cur_reg <= '0;
                    if (cmd != DIR_STOP) begin
                        state_reg <= ST_RUN;
                        dir_reg   <= cmd;
                    end
                end
                ST_RUN: begin
                    if (cmd != dir_reg) begin
                        // Any stop or reversal coasts first so the bridge never flips under load
                        state_reg    <= ST_DEAD;
                        dead_cnt_reg <= '0;
                        duty_cur_reg <= '0;
                    end else if (wrap) begin
                        duty_cur_reg <= duty_ramp;
                    end
                end
                ST_DEAD: begin
                    duty_cur_reg <= '0;
                    if (dead_done) begin
                        dead_cnt_reg <= '0;
                        if (cmd != DIR_STOP) begin
                            state_reg <= ST_RUN;
                            dir_reg   <= cmd;
                        end else begin
                            state_reg <= ST_STOP;
                        end
                    end else begin
                        dead_cnt_reg <= dead_cnt_reg + DEAD_W'(1);
                    end
                end
                default: begin
                    state_reg    <= ST_STOP;
                    duty_cur_reg <= '0;
                    dead_cnt_reg <= '0;
                end
            endcase

            // Outputs follow the state held during this cycle; only RUN drives the bridge
            in1_reg <= (state_reg == ST_RUN) && (dir_reg == DIR_REV);
            in2_reg <= (state_reg == ST_RUN) && (dir_reg == DIR_FWD);
            pwm_reg <= (state_reg == ST_RUN) && pwm_level;
        end
    end

    assign in1   = in1_reg;
    assign in2   = in2_reg;
    assign pwm   = pwm_reg;
    assign state = state_reg;

endmodule

// File: rtl/motor_pwm_drive.sv
// Dual H-bridge drive: synchronises the asynchronous per-side commands, runs the
// shared PWM period counter and feeds two independent motor channels.
module motor_pwm_drive
    import motor_pkg::*;
#(
    parameter int PWM_PERIOD = 1000,
    parameter int DUTY       = 600,
    parameter int RAMP_STEP  = 10,
    parameter int DEAD_CYC   = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic zuo1,
    input  logic zuo2,
    input  logic you1,
    input  logic you2,
    input  logic en1,
    input  logic en2,
    output logic l_in1,
    output logic l_in2,
    output logic r_in1,
    output logic r_in2,
    output logic l_pwm,
    output logic r_pwm,
    output logic dead_active
);

    localparam int CNT_W = cnt_width(PWM_PERIOD);

    // Per side the bits are {en, x2, x1}; side 0 is left, side 1 is right
    logic [SYNC_BITS-1:0] raw_bits;
    logic [SYNC_BITS-1:0] sync_bits;

    logic [CNT_W-1:0] pwm_cnt_reg;
    logic             wrap;
    logic             dead_active_reg;

    dir_t   side_cmd   [SIDES];
    logic   side_in1   [SIDES];
    logic   side_in2   [SIDES];
    logic   side_pwm   [SIDES];
    state_t side_state [SIDES];

    assign raw_bits = {en2, you2, you1, en1, zuo2, zuo1};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_BITS; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= raw_bits[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync_bits[gi] = sync_reg;
        end
    endgenerate

    assign wrap = (pwm_cnt_reg == CNT_W'(PWM_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_reg <= '0;
        end else if (wrap) begin
            pwm_cnt_reg <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + CNT_W'(1);
        end
    end

    generate
        for (gi = 0; gi < SIDES; gi++) begin : g_side
            assign side_cmd[gi] = decode_cmd(sync_bits[3*gi+2], sync_bits[3*gi], sync_bits[3*gi+1]);

            motor_channel #(
                .DUTY      (DUTY),
                .RAMP_STEP (RAMP_STEP),
                .DEAD_CYC  (DEAD_CYC),
                .CNT_W     (CNT_W)
            ) u_channel (
                .clk     (clk),
                .rst     (rst),
                .cmd     (side_cmd[gi]),
                .pwm_cnt (pwm_cnt_reg),
                .wrap    (wrap),
                .in1     (side_in1[gi]),
                .in2     (side_in2[gi]),
                .pwm     (side_pwm[gi]),
                .state   (side_state[gi])
            );
        end
    endgenerate

    // Registered from the channel states so it lines up with the gated bridge outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            dead_active_reg <= 1'b0;
        end else begin
            dead_active_reg <= (side_state[0] == ST_DEAD) || (side_state[1] == ST_DEAD);
        end
    end

    assign l_in1       = side_in1[0];
    assign l_in2       = side_in2[0];
    assign l_pwm       = side_pwm[0];
    assign r_in1       = side_in1[1];
    assign r_in2       = side_in2[1];
    assign r_pwm       = side_pwm[1];
    assign dead_active = dead_active_reg;

endmodule

// File: tb/tb_motor_pwm_drive.sv
// Scoreboard bench for motor_pwm_drive: a behavioural model predicts each cycle's
// outputs, a negedge monitor pops and compares them against the design.
module tb_motor_pwm_drive;

    localparam int P    = 10;
    localparam int D    = 6;
    localparam int STEP = 2;
    localparam int DC   = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic zuo1 = 1'b0, zuo2 = 1'b0, you1 = 1'b0, you2 = 1'b0, en1 = 1'b0, en2 = 1'b0;
    logic l_in1, l_in2, r_in1, r_in2, l_pwm, r_pwm, dead_active;

    always #5 clk = ~clk;

    motor_pwm_drive #(
        .PWM_PERIOD (P),
        .DUTY       (D),
        .RAMP_STEP  (STEP),
        .DEAD_CYC   (DC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .zuo1        (zuo1),
        .zuo2        (zuo2),
        .you1        (you1),
        .you2        (you2),
        .en1         (en1),
        .en2         (en2),
        .l_in1       (l_in1),
        .l_in2       (l_in2),
        .r_in1       (r_in1),
        .r_in2       (r_in2),
        .l_pwm       (l_pwm),
        .r_pwm       (r_pwm),
        .dead_active (dead_active)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int pushed = 0;
    int popped = 0;
    logic [6:0] exp_q[$];

    // Model: mode 0 idle, 1 driving, 2 coasting; dir +1 forward, -1 reverse.
    // Duty is derived from how many period wraps have elapsed while driving.
    int md[2], dr[2], wr[2], dl[2], h1[2], h2[2];
    int cnt;

    logic chk_dead = 1'b0;
    int   dead_run = 0;
    bit   dead_rst = 1'b0;

    function automatic int want(logic en, logic a, logic b);
        if (!en || (a == b)) return 0;
        return b ? 1 : -1;
    endfunction

    function automatic int duty_of(int s);
        int d;
        d = wr[s] * STEP;
        return (d > D) ? D : d;
    endfunction

    task automatic model_edge();
        logic [6:0] e;
        int  now[2];
        int  c;
        bit  wrap;
        e = '0;
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                md[s] = 0; dr[s] = 0; wr[s] = 0; dl[s] = 0; h1[s] = 0; h2[s] = 0;
            end
            cnt = 0;
        end else begin
            wrap = (cnt == P - 1);
            e[6] = (md[0] == 1) && (dr[0] == -1);
            e[5] = (md[0] == 1) && (dr[0] == 1);
            e[4] = (md[1] == 1) && (dr[1] == -1);
            e[3] = (md[1] == 1) && (dr[1] == 1);
            e[2] = (md[0] == 1) && (cnt < duty_of(0));
            e[1] = (md[1] == 1) && (cnt < duty_of(1));
            e[0] = (md[0] == 2) || (md[1] == 2);
            now[0] = want(en1, zuo1, zuo2);
            now[1] = want(en2, you1, you2);
            for (int s = 0; s < 2; s++) begin
                c = h2[s];
                if (md[s] == 0) begin
                    if (c != 0) begin md[s] = 1; dr[s] = c; wr[s] = 0; end
                end else if (md[s] == 1) begin
                    if (c != dr[s]) begin md[s] = 2; dl[s] = DC; end
                    else if (wrap && wr[s] < 1000) wr[s]++;
                end else begin
                    dl[s]--;
                    if (dl[s] == 0) begin
                        if (c != 0) begin md[s] = 1; dr[s] = c; wr[s] = 0; end
                        else md[s] = 0;
                    end
                end
                h2[s] = h1[s];
                h1[s] = now[s];
            end
            cnt = wrap ? 0 : cnt + 1;
        end
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
        end
    endtask

    task automatic set_left(logic e, logic a, logic b);
        en1 = e; zuo1 = a; zuo2 = b;
    endtask

    task automatic set_right(logic e, logic a, logic b);
        en2 = e; you1 = a; you2 = b;
    endtask

    logic [6:0] mon_exp, mon_act;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {l_in1, l_in2, r_in1, r_in2, l_pwm, r_pwm, dead_active};
            popped++;
            n_cmp++;
            if (mon_act !== mon_exp) begin
                n_bad++;
                $display("FAIL outputs t=%0t {l_in1,l_in2,r_in1,r_in2,l_pwm,r_pwm,dead} got %b want %b",
                         $time, mon_act, mon_exp);
            end
        end
        if (dead_active === 1'b1) begin
            dead_run++;
            if (rst) dead_rst = 1'b1;
        end else if (dead_run > 0) begin
            if (chk_dead && !dead_rst) begin
                n_cmp++;
                if (dead_run != DC) begin
                    n_bad++;
                    $display("FAIL dead_length t=%0t got %0d cycles want %0d", $time, dead_run, DC);
                end
            end
            dead_run = 0;
            dead_rst = 1'b0;
        end
    end

    initial begin
        // Reset held with a forward command present
        rst = 1'b1;
        set_left(1'b1, 1'b0, 1'b1);
        set_right(1'b1, 1'b0, 1'b0);
        step(3);
        rst = 1'b0;
        chk_dead = 1'b1;
        step(45);

        // Reversal at full duty, then stop, then forward re-asserted mid-coast
        set_left(1'b1, 1'b1, 1'b0);
        step(60);
        set_left(1'b0, 1'b1, 1'b0);
        step(8);
        set_left(1'b1, 1'b0, 1'b1);
        step(60);
        set_left(1'b0, 1'b0, 1'b1);
        step(40);

        // Illegal pair from RUN behaves as stop
        set_left(1'b1, 1'b0, 1'b1);
        step(30);
        set_left(1'b1, 1'b1, 1'b1);
        step(40);

        // Both sides running, then left stop and right reversal together
        set_left(1'b1, 1'b0, 1'b1);
        set_right(1'b1, 1'b1, 1'b0);
        step(40);
        set_left(1'b0, 1'b0, 1'b1);
        set_right(1'b1, 1'b0, 1'b1);
        step(60);

        // Reset in the middle of a coast interval
        set_left(1'b1, 1'b0, 1'b1);
        step(30);
        set_left(1'b1, 1'b1, 1'b0);
        step(13);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(40);

        // Randomised commands, glitches and occasional resets
        chk_dead = 1'b0;
        for (int i = 0; i < 90; i++) begin
            set_left($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            set_right($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                step($urandom_range(1, 3));
                rst = 1'b0;
            end
            step($urandom_range(1, 40));
        end

        step(5);
        @(negedge clk);
        #1;
        n_cmp++;
        if (popped != pushed) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d popped want %0d", popped, pushed);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/motor_pwm_drive.md
# motor_pwm_drive

Downstream motor stage of the obstacle-avoidance path: consumes the per-side direction/enable commands produced by the avoidance decision logic and drives the dual H-bridge (L298N-style) with PWM speed control. Each wheel side (left = zuo/en1, right = you/en2) gets a soft-start duty ramp and a mandatory coast (dead) interval on every stop or direction reversal, so the bridge never reverses under load. The commands arrive from asynchronous decision logic and are synchronised here.

## Interface
- PWM_PERIOD, 1000: PWM period in clk cycles (≥2).
- DUTY, 600: target high cycles per period; ≥PWM_PERIOD means constant high.
- RAMP_STEP, 10: duty increment applied at each PWM period wrap during soft start (≥1).
- DEAD_CYC, 50000: coast cycles inserted on stop/reversal (≥1).

- clk  in  1  system clock, sole clock.
- rst  in  1  synchronous, active-high reset.
- zuo1, zuo2  in  1  left direction command pair (async).
- you1, you2  in  1  right direction command pair (async).
- en1, en2  in  1  left / right enable (async).
- l_in1, l_in2  out  1  left bridge direction lines.
- r_in1, r_in2  out  1  right bridge direction lines.
- l_pwm, r_pwm  out  1  left / right bridge enable (PWM).
- dead_active  out  1  high while either side is in DEAD.

## Operation
- Inputs pass through 2-FF synchronisers; reset value 0 (decodes as STOP).
- Per-side decode of (en, x1, x2): en=0 or x1==x2 → STOP; x1=0,x2=1 → FWD; x1=1,x2=0 → REV.
- Shared free-running pwm_cnt 0..PWM_PERIOD-1; wrap = cycle where pwm_cnt==PWM_PERIOD-1.
- Per-side FSM states STOP, RUN, DEAD; latched dir; duty_cur; dead_cnt.
  - STOP: in1=in2=0, pwm=0, duty_cur=0. cmd FWD/REV → RUN, latch dir, duty_cur=0.
  - RUN: FWD → in1=0,in2=1; REV → in1=1,in2=0. pwm = (pwm_cnt < duty_cur). On wrap duty_cur = min(duty_cur+RAMP_STEP, DUTY), saturating, no overflow. cmd==latched dir → stay; cmd STOP or opposite dir → DEAD, dead_cnt=0.
  - DEAD: in1=in2=0, pwm=0, duty_cur=0. dead_cnt counts to DEAD_CYC-1; during DEAD cmd is ignored. On final count: cmd FWD/REV → RUN with new latched dir; STOP → STOP.
- Direction lines and pwm never both active across a reversal: in1 and in2 never simultaneously 1.
- duty_cur==0 → pwm constant 0; duty_cur≥PWM_PERIOD → constant 1.
- Sides are fully independent; dead_active = l_state==DEAD | r_state==DEAD.

## Timing
- All outputs registered; reset value of every output 0, FSMs STOP, pwm_cnt 0, duty_cur 0, dead_cnt 0.
- Latency: input change sampled at edge N → synchronised at N+1 → FSM state at N+2 → outputs at N+3.
- DEAD lasts exactly DEAD_CYC cycles (outputs low DEAD_CYC cycles before new dir appears).
- Ramp: first non-zero duty at first wrap after entering RUN; reaches DUTY after ceil(DUTY/RAMP_STEP) wraps.
- Input glitch shorter than 1 clk may be missed; no debounce beyond sync.
- rst mid-RUN or mid-DEAD: all outputs 0 at next edge, FSMs to STOP, counters cleared; post-reset commands need full N+3 latency.
- Simultaneous stop on one side and reversal on the other: each side handles its own transition in the same cycle.

## Structure
- Shared package/include motor_pkg: state encoding (STOP/RUN/DEAD), dir encoding (FWD/REV/STOP), decode function, counter width helper (clog2).
- Sub-module motor_channel (FSM, ramp, dead counter, in/pwm output regs), instantiated twice; top holds synchronisers and shared pwm_cnt.

## Test plan
Params for bench: PWM_PERIOD=10, DUTY=6, RAMP_STEP=2, DEAD_CYC=20.
- Reset: hold rst 3 cycles with en1=en2=1, zuo2=1 → all outputs 0 throughout; after release l_in2=1 at 3rd edge.
- Soft start: left FWD from STOP → l_pwm high 0,2,4,6,6 cycles in successive periods; l_in1=0,l_in2=1.
- Reversal: left RUN FWD at DUTY, switch to zuo1=1,zuo2=0 → l_in*/l_pwm 0 for exactly 20 cycles, dead_active=1, then l_in1=1 and ramp restarts from 0.
- Stop: en1→0 in RUN → DEAD 20 cycles, then STOP; re-asserting FWD mid-DEAD has no effect until DEAD ends, then RUN.
- Illegal cmd zuo1=zuo2=1 with en1=1 → treated as STOP (DEAD then STOP); in1/in2 never both 1.
- Reset mid-DEAD at dead_cnt=10 → outputs 0 next edge, dead_active 0, restart proceeds from STOP.
